// File: rtl/instr_mem_fetch.sv
// Parametrised instruction memory with a registered, stallable fetch stage and a run-time load port.
// Illegal fetches/loads are reported; illegal loads never write.
module instr_mem_fetch #(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter int                ADDR_W    = 32,
  parameter int                BYTE_ADDR = 1,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              stall,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  output logic              fetch_fault,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data;
  logic              valid_q;
  logic              fault_q;
  logic [ADDR_W-1:0] fetch_idx;
  logic [ADDR_W-1:0] load_idx;
  logic              fetch_ok;
  logic              load_ok;
  logic              fetch_take;

  function automatic logic [ADDR_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return (BYTE_ADDR != 0) ? (a >> 2) : a;
  endfunction

  // Range check on the full-width index so high address bits can never alias into the array.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    logic misaligned;
    misaligned = (BYTE_ADDR != 0) && (a[1:0] != 2'b00);
    return !misaligned && ({1'b0, word_idx(a)} < DEPTH_EXT);
  endfunction

  assign fetch_idx  = word_idx(fetch_addr);
  assign load_idx   = word_idx(load_addr);
  assign fetch_ok   = addr_ok(fetch_addr);
  assign load_ok    = addr_ok(load_addr);
  assign fetch_take = !reset && !stall && fetch_req && fetch_ok;

  // RAM block: no reset on the array or its read register, so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (fetch_take)
      rd_data <= mem[fetch_idx[IDX_W-1:0]];
    if (!reset && load_en && load_ok)
      mem[load_idx[IDX_W-1:0]] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_err <= load_en && !load_ok;
      if (!stall) begin
        valid_q <= fetch_req;
        fault_q <= fetch_req && !fetch_ok;
      end
    end
  end

  assign instr_out   = (valid_q && !fault_q) ? rd_data : NOP_INSTR;
  assign instr_valid = valid_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Self-checking bench for instr_mem_fetch: byte-addressed 1024-word instance driven
// against a reference model and scoreboard, plus a word-addressed 16-word instance.
module tb_instr_mem_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // byte-addressed, DEPTH=1024
  logic        a_reset = 1'b0, a_req = 1'b0, a_stall = 1'b0, a_len = 1'b0;
  logic [31:0] a_faddr = '0, a_laddr = '0, a_ldata = '0;
  logic [31:0] a_instr;
  logic        a_valid, a_fault, a_lerr;

  instr_mem_fetch dut_a (
    .clk(clk), .reset(a_reset), .fetch_req(a_req), .fetch_addr(a_faddr), .stall(a_stall),
    .instr_out(a_instr), .instr_valid(a_valid), .fetch_fault(a_fault),
    .load_en(a_len), .load_addr(a_laddr), .load_data(a_ldata), .load_err(a_lerr)
  );

  // word-addressed, DEPTH=16
  logic        b_reset = 1'b0, b_req = 1'b0, b_stall = 1'b0, b_len = 1'b0;
  logic [31:0] b_faddr = '0, b_laddr = '0, b_ldata = '0;
  logic [31:0] b_instr;
  logic        b_valid, b_fault, b_lerr;

  instr_mem_fetch #(.DEPTH(16), .BYTE_ADDR(0)) dut_b (
    .clk(clk), .reset(b_reset), .fetch_req(b_req), .fetch_addr(b_faddr), .stall(b_stall),
    .instr_out(b_instr), .instr_valid(b_valid), .fetch_fault(b_fault),
    .load_en(b_len), .load_addr(b_laddr), .load_data(b_ldata), .load_err(b_lerr)
  );

  typedef struct {
    logic [31:0] d;
    logic        v;
    logic        f;
    logic        le;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m [1024];
  logic [31:0] md = '0;
  logic        mv = 1'b0, mf = 1'b0, mle = 1'b0;

  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < 32'd4096);
  endfunction

  // One clock on instance A: model the edge, push expectation, drive, pop and compare.
  task automatic step(input string nm, input logic rst, input logic req, input logic st,
                      input logic [31:0] fa, input logic len, input logic [31:0] la,
                      input logic [31:0] ld);
    exp_t e;
    if (rst) begin
      md = 32'h0; mv = 1'b0; mf = 1'b0; mle = 1'b0;
    end else begin
      if (!st) begin
        if (req && legal(fa)) begin
          md = m[fa[11:2]]; mv = 1'b1; mf = 1'b0;
        end else if (req) begin
          md = 32'h0; mv = 1'b1; mf = 1'b1;
        end else begin
          md = 32'h0; mv = 1'b0; mf = 1'b0;
        end
      end
      mle = len && !legal(la);
      if (len && legal(la)) m[la[11:2]] = ld;
    end
    e.d = md; e.v = mv; e.f = mf; e.le = mle;
    sb.push_back(e);
    a_reset = rst; a_req = req; a_stall = st; a_faddr = fa;
    a_len = len; a_laddr = la; a_ldata = ld;
    @(posedge clk); #1;
    a_reset = 1'b0; a_req = 1'b0; a_stall = 1'b0; a_len = 1'b0;
    e = sb.pop_front();
    total += 4;
    if (a_instr !== e.d) begin bad++; $display("FAIL %s instr_out got=%h exp=%h", nm, a_instr, e.d); end
    if (a_valid !== e.v) begin bad++; $display("FAIL %s instr_valid got=%b exp=%b", nm, a_valid, e.v); end
    if (a_fault !== e.f) begin bad++; $display("FAIL %s fetch_fault got=%b exp=%b", nm, a_fault, e.f); end
    if (a_lerr  !== e.le) begin bad++; $display("FAIL %s load_err got=%b exp=%b", nm, a_lerr, e.le); end
  endtask

  task automatic fetch(input string nm, input logic [31:0] fa);
    step(nm, 1'b0, 1'b1, 1'b0, fa, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic load(input string nm, input logic [31:0] la, input logic [31:0] ld);
    step(nm, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, la, ld);
  endtask

  task automatic want(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin bad++; $display("FAIL %s got=%h exp=%h", nm, got, exp); end
  endtask

  task automatic test_reset();
    step("reset0", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    step("reset1", 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    want("reset_instr", a_instr, 32'h0);
    want("reset_valid", {31'h0, a_valid}, 32'h0);
  endtask

  task automatic test_load_fetch();
    load("ld0", 32'h0, 32'h00221820);
    load("ld4", 32'h4, 32'hAC010000);
    load("ld8", 32'h8, 32'h8C220004);
    load("ld20", 32'd20, 32'h00001820);
    fetch("fetch0", 32'h0);
    want("fetch0_const", a_instr, 32'h00221820);
    fetch("fetch4", 32'h4);
    want("fetch4_const", a_instr, 32'hAC010000);
    want("fetch4_valid", {31'h0, a_valid}, 32'h1);
  endtask

  task automatic test_stall();
    fetch("stall_pre", 32'h4);
    for (int i = 0; i < 3; i++) begin
      step("stall_hold", 1'b0, 1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 32'h0);
      want("stall_hold_const", a_instr, 32'hAC010000);
    end
    fetch("stall_post", 32'h8);
    want("stall_post_const", a_instr, 32'h8C220004);
  endtask

  task automatic test_faults();
    fetch("misaligned", 32'h6);
    want("misaligned_fault", {31'h0, a_fault}, 32'h1);
    fetch("out_of_range", 32'h1000);
    want("oor_instr", a_instr, 32'h0);
    fetch("high_bit", 32'h8000_0000);
    load("bad_load", 32'h1000, 32'hDEADBEEF);
    want("bad_load_err", {31'h0, a_lerr}, 32'h1);
    load("misaligned_load", 32'h2, 32'hDEADBEEF);
    step("err_clear", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    fetch("mem0_kept", 32'h0);
    want("mem0_kept_const", a_instr, 32'h00221820);
  endtask

  task automatic test_rbw();
    step("rbw_same", 1'b0, 1'b1, 1'b0, 32'd20, 1'b1, 32'd20, 32'h00411822);
    want("rbw_old", a_instr, 32'h00001820);
    fetch("rbw_next", 32'd20);
    want("rbw_new", a_instr, 32'h00411822);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++)
      load("b2b_load", 32'd40 + 32'(i * 4), $urandom);
    for (int i = 0; i < 8; i++)
      fetch("b2b_fetch", 32'd40 + 32'(i * 4));
    step("bubble", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    fetch("last_word", 32'd4092);
    // load during stall must still write
    step("stall_load", 1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 32'd4092, 32'h12345678);
    fetch("stall_load_rd", 32'd4092);
    want("stall_load_const", a_instr, 32'h12345678);
  endtask

  task automatic test_reset_stall();
    fetch("rs_pre", 32'h4);
    step("rs_stall", 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    step("rs_reset", 1'b1, 1'b1, 1'b1, 32'h0, 1'b1, 32'h0, 32'hFFFFFFFF);
    want("rs_valid", {31'h0, a_valid}, 32'h0);
    fetch("rs_mem0", 32'h0);
    want("rs_mem0_const", a_instr, 32'h00221820);
  endtask

  task automatic test_word_mode();
    b_reset = 1'b1;
    @(posedge clk); #1;
    b_reset = 1'b0;
    want("w_reset_valid", {31'h0, b_valid}, 32'h0);
    b_len = 1'b1; b_laddr = 32'd3; b_ldata = 32'h10210001;
    @(posedge clk); #1;
    b_len = 1'b0;
    want("w_load_err", {31'h0, b_lerr}, 32'h0);
    b_req = 1'b1; b_faddr = 32'd3;
    @(posedge clk); #1;
    want("w_fetch3", b_instr, 32'h10210001);
    want("w_fetch3_fault", {31'h0, b_fault}, 32'h0);
    b_faddr = 32'd16;
    @(posedge clk); #1;
    want("w_fetch16_fault", {31'h0, b_fault}, 32'h1);
    want("w_fetch16_instr", b_instr, 32'h0);
    b_req = 1'b0; b_len = 1'b1; b_laddr = 32'd16;
    @(posedge clk); #1;
    b_len = 1'b0;
    want("w_load16_err", {31'h0, b_lerr}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_load_fetch();
    test_stall();
    test_faults();
    test_rbw();
    test_back_to_back();
    test_reset_stall();
    test_word_mode();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_mem_fetch.md
Name: instr_mem_fetch

Overview:
Parametrised instruction memory with a registered fetch stage for the single-cycle/pipelined CPU datapath. It generalises the fixed 1024x32 word-indexed ROM in four ways: configurable width and depth; byte- or word-addressed mode; a stall/valid fetch handshake; and a load port so test programs can be written at run time. Misaligned and out-of-range fetches are reported instead of silently reading garbage.

Parameters:
DATA_W, 32, instruction width in bits
DEPTH, 1024, number of instruction words (power of two, >= 2)
ADDR_W, 32, width of fetch_addr and load_addr
BYTE_ADDR, 1, 1 = addresses are byte addresses (word index = addr >> 2); 0 = addresses are word indices
NOP_INSTR, 32'h00000000, value driven on instr_out after reset, on faults and for bubbles

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
fetch_req  input  1  fetch request for fetch_addr this cycle
fetch_addr  input  ADDR_W  PC of the requested instruction
stall  input  1  downstream stall; holds the fetch output registers
instr_out  output  DATA_W  fetched instruction (registered)
instr_valid  output  1  instr_out holds a result of an accepted fetch
fetch_fault  output  1  accepted fetch was misaligned or out of range
load_en  input  1  write load_data into memory this cycle
load_addr  input  ADDR_W  load address (same addressing mode as fetch)
load_data  input  DATA_W  word to write
load_err  output  1  registered pulse: the last load was misaligned or out of range and was dropped

Behaviour:
- One clock domain; reset is synchronous and active-high, named reset; clock named clk.
- Index calculation: idx = BYTE_ADDR ? addr[ADDR_W-1:2] : addr.
  - Misaligned only when BYTE_ADDR=1 and addr[1:0] != 0.
  - Out of range when idx >= DEPTH. Compare the full-width idx; do not truncate before the compare.
- Reset, on the clock edge where reset=1:
  - instr_out = NOP_INSTR, instr_valid = 0, fetch_fault = 0, load_err = 0.
  - Memory contents are not cleared.
  - A load or fetch presented in the same cycle as reset is ignored.
  - Reset overrides stall.
- Fetch, accepted when fetch_req=1 and stall=0. Latency is 1 cycle. On the next edge:
  - Legal address: instr_out = mem[idx], instr_valid = 1, fetch_fault = 0.
  - Misaligned or out of range: instr_out = NOP_INSTR, instr_valid = 1, fetch_fault = 1.
- fetch_req=0 and stall=0: instr_out = NOP_INSTR, instr_valid = 0, fetch_fault = 0 (bubble).
- stall=1: instr_out, instr_valid and fetch_fault hold their values; fetch_req is ignored and the request is not queued. The requester re-presents the request after the stall.
- Load:
  - load_en=1 with a legal load_addr writes mem[idx] = load_data on the edge; load_err = 0 next cycle.
  - An illegal load_addr performs no write; load_err = 1 for one cycle.
  - Load writes proceed regardless of stall.
- Simultaneous load and fetch to the same idx: the fetch returns the OLD word (read-before-write). The new word is visible to fetches accepted on the following cycle or later.
- Wrap-around: none. An address beyond DEPTH faults rather than aliasing.
- Memory is a single-write, single-synchronous-read array, so it infers block RAM. Only the NOP/fault substitution mux sits after the RAM output register.

Test Plan:
- Reset, then load_en writes 32'h00221820 at byte addr 0 and 32'hAC010000 at addr 4; then fetch addr 0, then 4 -> instr_out = 32'h00221820 then 32'hAC010000, each one cycle after request, instr_valid=1, fetch_fault=0.
- Fetch addr 4, then stall=1 for 3 cycles while fetch_addr changes to 8 -> instr_out stays 32'hAC010000 and instr_valid stays 1 through the stall; after stall drops, fetch 8 returns mem[2] next cycle.
- Misaligned fetch addr 32'h00000006, and out-of-range fetch addr 32'h00001000 (DEPTH=1024) -> instr_out=NOP_INSTR, fetch_fault=1, instr_valid=1; load_en to addr 32'h00001000 -> load_err=1 for one cycle, mem[0] unchanged.
- Same-cycle load of 32'h00411822 and fetch, both at addr 20 (old word 32'h00001820) -> instr_out = 32'h00001820; a fetch of addr 20 on the next cycle -> 32'h00411822.
- BYTE_ADDR=0, DEPTH=16 instance: load word addr 3 = 32'h10210001, fetch addr 3 -> 32'h10210001; fetch addr 16 -> fetch_fault=1.
- Assert reset during a stalled valid output and with load_en=1 at addr 0 -> next cycle instr_valid=0, instr_out=NOP_INSTR; mem[0] keeps its prior value.
